dpram_req_arbiter: RTL and testbench
====================================

// Module: dpram_req_arbiter
// PURPOSE
//   Shares one dual-port SRAM (two independent ports A/B, sync write, 1-cycle registered read) among NREQ requesters.
//   Each cycle grants up to two requests, one per RAM port, in round-robin order.
//   Resolves same-address hazards between the two ports and routes read data back to the issuing requester.
//   Sits between the requester fabric and the dual-port RAM macro.
// PARAMETERS
//   NREQ  4   number of requesters (2..8)
//   AW    8   RAM address width
//   DW    16  RAM data width
// PORTS
//   clk          in   1        clock, all state on rising edge
//   rst          in   1        reset, asynchronous, active-high
//   req_valid    in   NREQ     request pending, one bit per requester
//   req_we       in   NREQ     1 = write, 0 = read
//   req_addr     in   NREQ*AW  packed addresses, requester i at [i*AW +: AW]
//   req_wdata    in   NREQ*DW  packed write data
//   req_ready    out  NREQ     grant; request accepted when valid & ready
//   rsp_valid    out  NREQ     read data valid for requester i (reads only)
//   rsp_rdata    out  NREQ*DW  per-requester read data, held until next response to it
//   ram_we_a     out  1        RAM port A write enable
//   ram_addr_a   out  AW       RAM port A address
//   ram_wdata_a  out  DW       RAM port A write data
//   ram_rdata_a  in   DW       RAM port A read data (valid cycle after address)
//   ram_we_b / ram_addr_b / ram_wdata_b / ram_rdata_b   same as port A, for port B
//   coll_cnt     out  16       collision counter (only with DPRAM_ARB_COLL_CNT_EN)
// BEHAVIOUR
//   - Reset: ptr=0, rsp_valid=0, rsp_rdata=0, response pipe cleared, coll_cnt=0.
//     While rst is high: req_ready=0, ram_we_a=0, ram_we_b=0.
//   - Pick: scan requesters ptr, ptr+1 .. ptr+NREQ-1 (mod NREQ).
//     First valid requester -> port A; next valid requester -> port B.
//     Grant is combinational from current inputs; req_ready is one-hot-per-port (max 2 bits set).
//   - Hazard: if both picks have equal addresses and at least one is a write, the B grant is withdrawn.
//     The B requester retries next cycle; it does not lose its place.
//     Equal-address read/read is allowed on both ports.
//   - Pointer update: ptr <= (last granted index + 1) mod NREQ; unchanged when nothing is granted.
//     Wrap from NREQ-1 to 0. This guarantees starvation-free service within NREQ cycles.
//   - RAM drive: port X is driven from its granted requester (addr, wdata, we).
//     An idle port drives we=0, addr=0, wdata=0.
//   - Read latency:
//     * Read granted in cycle N: rsp_valid[i]=1 in cycle N+1 only, with rsp_rdata[i]=ram_rdata_X.
//     * Routing uses registered {valid, id, port}.
//     * Writes get no response; acceptance is the handshake.
//   - Back-to-back: a requester may be granted every cycle. Responses are in order per requester.
//   - Requester identity: one requester is never granted both ports in the same cycle.
//   - Reset mid-operation: pending response is dropped; rsp_valid stays 0; RAM contents untouched.
// CONFIGURATION
//   DPRAM_ARB_COLL_CNT_EN defined:
//     - coll_cnt port exists.
//     - Increments (saturating at 16'hFFFF) each cycle a B grant is withdrawn by the hazard rule.
//   DPRAM_ARB_COLL_CNT_EN undefined:
//     - Port and counter are absent.
//     - All other behaviour is identical.
// STRUCTURE
//   - Package dpram_arb_pkg: default NREQ/AW/DW, and a requester-index width constant $clog2(NREQ).
//   - Sub-module rr_pick:
//     * Inputs: mask, start index. Outputs: first set index + found flag.
//     * Instantiated twice: for the B pick, the A winner is masked out and the start index is A+1.
// TESTING
//   1. Reset: assert rst with all valid=1 -> req_ready=0, ram_we_a/b=0, rsp_valid=0, coll_cnt=0.
//   2. Single read:
//      - req 2 reads addr 0x10 holding 0xBEEF.
//      - Expect ready[2]=1, port A addr=0x10; next cycle rsp_valid=4'b0100, rsp_rdata[2]=0xBEEF.
//   3. Round-robin, all four requesters valid with distinct addresses, held:
//      - cycle 0 grants A=0, B=1; cycle 1 grants A=2, B=3; cycle 2 grants A=0, B=1.
//   4. Write hazard:
//      - ptr=0; req 0 writes 0x22, req 1 reads 0x22.
//      - Expect only ready[0]; next cycle req 1 is granted on port A and receives the new data; coll_cnt=1.
//   5. Read/read, same address 0x05 from req 1 and req 3 -> both granted same cycle; both get equal rsp_rdata.
//   6. Mid-op reset: grant a read, assert rst the next cycle -> rsp_valid stays 0 and ptr=0 after release.

Source files
------------

// File: rtl/dpram_arb_pkg.sv
// Shared defaults and index helpers for the dual-port RAM request arbiter.
package dpram_arb_pkg;

    localparam int unsigned NREQ_DEFAULT = 4;
    localparam int unsigned AW_DEFAULT   = 8;
    localparam int unsigned DW_DEFAULT   = 16;
    localparam int unsigned IDXW_DEFAULT = $clog2(NREQ_DEFAULT);

    // Round-robin successor of idx among n requesters.
    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set bit of mask at or after start, wrapping.
module rr_pick
    import dpram_arb_pkg::*;
#(
    parameter int unsigned N  = NREQ_DEFAULT,
    parameter int unsigned IW = $clog2(N)
) (
    input  logic [N-1:0]  mask,
    input  logic [IW-1:0] start,
    output logic [IW-1:0] idx,
    output logic          found
);

    // Smallest wrap distance from start wins.
    always_comb begin
        int unsigned best;
        int unsigned d;
        best  = N;
        d     = 0;
        idx   = '0;
        found = 1'b0;
        for (int unsigned j = 0; j < N; j++) begin
            d = (j + N - 32'(start)) % N;
            if (mask[j] && d < best) begin
                best  = d;
                idx   = IW'(j);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dpram_req_arbiter.sv
// Two-port round-robin arbiter in front of a dual-port SRAM with read-data routing.
// Optional collision counter port enabled by DPRAM_ARB_COLL_CNT_EN.
module dpram_req_arbiter
    import dpram_arb_pkg::*;
#(
    parameter int unsigned NREQ = NREQ_DEFAULT,
    parameter int unsigned AW   = AW_DEFAULT,
    parameter int unsigned DW   = DW_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ-1:0]   req_we,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_wdata,
    output logic [NREQ-1:0]   req_ready,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [NREQ*DW-1:0] rsp_rdata,
    output logic              ram_we_a,
    output logic [AW-1:0]     ram_addr_a,
    output logic [DW-1:0]     ram_wdata_a,
    input  logic [DW-1:0]     ram_rdata_a,
    output logic              ram_we_b,
    output logic [AW-1:0]     ram_addr_b,
    output logic [DW-1:0]     ram_wdata_b,
    input  logic [DW-1:0]     ram_rdata_b
`ifdef DPRAM_ARB_COLL_CNT_EN
    ,
    output logic [15:0]       coll_cnt
`endif
);

    localparam int unsigned IW = $clog2(NREQ);

    logic [IW-1:0]   ptr;
    logic [IW-1:0]   a_idx, b_idx, b_start;
    logic            a_found, b_found;
    logic [NREQ-1:0] b_mask;
    logic            a_we, b_we;
    logic [AW-1:0]   a_addr, b_addr;
    logic            hazard, grant_a, grant_b;

    logic [AW-1:0]   addr_arr  [NREQ];
    logic [DW-1:0]   wdata_arr [NREQ];
    logic [DW-1:0]   rdata_q   [NREQ];
    logic [DW-1:0]   live      [NREQ];

    logic            pa_v, pb_v;
    logic [IW-1:0]   pa_id, pb_id;

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign addr_arr[g]  = req_addr[g*AW +: AW];
        assign wdata_arr[g] = req_wdata[g*DW +: DW];
    end

    rr_pick #(.N(NREQ), .IW(IW)) u_pick_a (
        .mask  (req_valid),
        .start (ptr),
        .idx   (a_idx),
        .found (a_found)
    );

    // B scans from just after A with A removed, so it is the next requester in order.
    assign b_mask  = req_valid & ~(NREQ'(1) << a_idx);
    assign b_start = IW'(rr_next(32'(a_idx), NREQ));

    rr_pick #(.N(NREQ), .IW(IW)) u_pick_b (
        .mask  (b_mask),
        .start (b_start),
        .idx   (b_idx),
        .found (b_found)
    );

    assign a_we    = req_we[a_idx];
    assign b_we    = req_we[b_idx];
    assign a_addr  = addr_arr[a_idx];
    assign b_addr  = addr_arr[b_idx];
    assign hazard  = a_found && b_found && (a_addr == b_addr) && (a_we || b_we);
    assign grant_a = a_found && !rst;
    assign grant_b = b_found && !hazard && !rst;

    always_comb begin
        req_ready = '0;
        if (grant_a) req_ready[a_idx] = 1'b1;
        if (grant_b) req_ready[b_idx] = 1'b1;
    end

    always_comb begin
        ram_we_a    = 1'b0;
        ram_addr_a  = '0;
        ram_wdata_a = '0;
        ram_we_b    = 1'b0;
        ram_addr_b  = '0;
        ram_wdata_b = '0;
        if (grant_a) begin
            ram_we_a    = a_we;
            ram_addr_a  = a_addr;
            ram_wdata_a = wdata_arr[a_idx];
        end
        if (grant_b) begin
            ram_we_b    = b_we;
            ram_addr_b  = b_addr;
            ram_wdata_b = wdata_arr[b_idx];
        end
    end

    // A withdrawn B leaves ptr at A+1, so the B requester is scanned first next cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (grant_b) begin
            ptr <= IW'(rr_next(32'(b_idx), NREQ));
        end else if (grant_a) begin
            ptr <= IW'(rr_next(32'(a_idx), NREQ));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pa_v  <= 1'b0;
            pb_v  <= 1'b0;
            pa_id <= '0;
            pb_id <= '0;
        end else begin
            pa_v  <= grant_a && !a_we;
            pb_v  <= grant_b && !b_we;
            pa_id <= a_idx;
            pb_id <= b_idx;
        end
    end

    always_comb begin
        rsp_valid = '0;
        rsp_rdata = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            live[i] = ram_rdata_a;
            if (pb_v && 32'(pb_id) == i) begin
                rsp_valid[i] = 1'b1;
                live[i]      = ram_rdata_b;
            end
            if (pa_v && 32'(pa_id) == i) begin
                rsp_valid[i] = 1'b1;
                live[i]      = ram_rdata_a;
            end
            rsp_rdata[i*DW +: DW] = rsp_valid[i] ? live[i] : rdata_q[i];
        end
    end

    // Live RAM data is forwarded in the response cycle; the hold register keeps it afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREQ; i++) rdata_q[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < NREQ; i++) begin
                if (rsp_valid[i]) rdata_q[i] <= live[i];
            end
        end
    end

`ifdef DPRAM_ARB_COLL_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            coll_cnt <= '0;
        end else if (hazard && coll_cnt != 16'hFFFF) begin
            coll_cnt <= coll_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dpram_req_arbiter.sv
// Randomized scoreboard bench for dpram_req_arbiter with a queue-based reference model.
module tb_dpram_req_arbiter;

    localparam int NREQ = 4;
    localparam int AW   = 8;
    localparam int DW   = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              load = 1'b0;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ-1:0]   req_we = '0;
    logic [NREQ*AW-1:0] req_addr = '0;
    logic [NREQ*DW-1:0] req_wdata = '0;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ-1:0]   rsp_valid;
    logic [NREQ*DW-1:0] rsp_rdata;
    logic              ram_we_a, ram_we_b;
    logic [AW-1:0]     ram_addr_a, ram_addr_b;
    logic [DW-1:0]     ram_wdata_a, ram_wdata_b;
    logic [DW-1:0]     ram_rdata_a, ram_rdata_b;
`ifdef DPRAM_ARB_COLL_CNT_EN
    logic [15:0]       coll_cnt;
`endif

    int total = 0;
    int bad   = 0;
    int cyc_now = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc_now <= cyc_now + 1;

    dpram_req_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_we      (req_we),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .ram_we_a    (ram_we_a),
        .ram_addr_a  (ram_addr_a),
        .ram_wdata_a (ram_wdata_a),
        .ram_rdata_a (ram_rdata_a),
        .ram_we_b    (ram_we_b),
        .ram_addr_b  (ram_addr_b),
        .ram_wdata_b (ram_wdata_b),
        .ram_rdata_b (ram_rdata_b)
`ifdef DPRAM_ARB_COLL_CNT_EN
        ,
        .coll_cnt    (coll_cnt)
`endif
    );

    function automatic logic [DW-1:0] init_val(input int k);
        return (k == 16'h10) ? 16'hBEEF : 16'(k * 37 ^ 16'hA5C3);
    endfunction

    // Dual-port RAM macro: sync write, registered read.
    logic [DW-1:0] ram [256];
    always @(posedge clk) begin
        if (load) begin
            for (int k = 0; k < 256; k++) ram[k] <= init_val(k);
        end else begin
            if (ram_we_a) ram[ram_addr_a] <= ram_wdata_a;
            if (ram_we_b) ram[ram_addr_b] <= ram_wdata_b;
        end
        ram_rdata_a <= ram[ram_addr_a];
        ram_rdata_b <= ram[ram_addr_b];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_now);
        end
    endtask

    // Reference model state
    typedef struct {
        int            id;
        int            cyc;
        logic [DW-1:0] data;
    } exp_t;
    exp_t          sb[$];
    logic [DW-1:0] ref_mem [256];
    int            ref_ptr = 0;
    int            coll_exp = 0;

    function automatic logic [AW-1:0] addr_of(input int i);
        return req_addr[i*AW +: AW];
    endfunction

    function automatic logic [DW-1:0] wdata_of(input int i);
        return req_wdata[i*DW +: DW];
    endfunction

    task automatic check_cycle();
        int            order[$];
        int            ea, eb, last;
        logic [NREQ-1:0] er;
        logic          ewa, ewb;
        logic [AW-1:0] eaa, eab;
        logic [DW-1:0] eda, edb;
        ea = -1; eb = -1; er = '0;
        ewa = 0; ewb = 0; eaa = '0; eab = '0; eda = '0; edb = '0;
        if (!rst) begin
            for (int k = 0; k < NREQ; k++)
                if (req_valid[(ref_ptr + k) % NREQ]) order.push_back((ref_ptr + k) % NREQ);
            if (order.size() > 0) ea = order[0];
            if (order.size() > 1) eb = order[1];
        end
`ifdef DPRAM_ARB_COLL_CNT_EN
        chk("coll_cnt", coll_cnt, coll_exp);
`endif
        if (eb >= 0 && addr_of(ea) == addr_of(eb) && (req_we[ea] || req_we[eb])) begin
            eb = -1;
            if (coll_exp < 16'hFFFF) coll_exp++;
        end
        if (ea >= 0) begin
            er[ea] = 1'b1; ewa = req_we[ea]; eaa = addr_of(ea); eda = wdata_of(ea);
        end
        if (eb >= 0) begin
            er[eb] = 1'b1; ewb = req_we[eb]; eab = addr_of(eb); edb = wdata_of(eb);
        end
        chk("req_ready", req_ready, er);
        chk("ram_we_a", ram_we_a, ewa);
        chk("ram_addr_a", ram_addr_a, eaa);
        chk("ram_wdata_a", ram_wdata_a, eda);
        chk("ram_we_b", ram_we_b, ewb);
        chk("ram_addr_b", ram_addr_b, eab);
        chk("ram_wdata_b", ram_wdata_b, edb);
        if (ea >= 0 && !req_we[ea]) sb.push_back('{ea, cyc_now + 1, ref_mem[addr_of(ea)]});
        if (eb >= 0 && !req_we[eb]) sb.push_back('{eb, cyc_now + 1, ref_mem[addr_of(eb)]});
        if (ea >= 0 && req_we[ea]) ref_mem[addr_of(ea)] = wdata_of(ea);
        if (eb >= 0 && req_we[eb]) ref_mem[addr_of(eb)] = wdata_of(eb);
        if (ea >= 0) begin
            last = (eb >= 0) ? eb : ea;
            ref_ptr = (last + 1) % NREQ;
        end
        if (rst) begin
            ref_ptr  = 0;
            coll_exp = 0;
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a response.
    logic [DW-1:0] last_data [NREQ];
    initial begin
        for (int i = 0; i < NREQ; i++) last_data[i] = '0;
        forever begin
            @(negedge clk);
            if (rst) for (int i = 0; i < NREQ; i++) last_data[i] = '0;
            for (int i = 0; i < NREQ; i++) begin
                int pos;
                pos = -1;
                if (rsp_valid[i]) begin
                    for (int k = 0; k < sb.size(); k++)
                        if (pos < 0 && sb[k].id == i) pos = k;
                    if (pos < 0) begin
                        chk("rsp_unexpected", 32'(rsp_valid[i]), 0);
                    end else begin
                        chk("rsp_cycle", cyc_now, sb[pos].cyc);
                        chk("rsp_data", rsp_rdata[i*DW +: DW], sb[pos].data);
                        last_data[i] = sb[pos].data;
                        sb.delete(pos);
                    end
                end else begin
                    chk("rsp_hold", rsp_rdata[i*DW +: DW], last_data[i]);
                end
            end
            for (int k = sb.size() - 1; k >= 0; k--) begin
                if (sb[k].cyc < cyc_now) begin
                    chk("rsp_missing", 32'(rsp_valid[sb[k].id]), 1);
                    sb.delete(k);
                end
            end
        end
    end

    task automatic half();
        @(negedge clk);
        check_cycle();
    endtask

    task automatic fin();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic we,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[i] = v;
        req_we[i]    = we;
        req_addr[i*AW +: AW] = a;
        req_wdata[i*DW +: DW] = d;
    endtask

    task automatic idle();
        req_valid = '0;
        req_we    = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        sb.delete();
        req_valid = '1;
        half();
        chk("reset_ready", req_ready, 0);
        chk("reset_rsp_valid", rsp_valid, 0);
        fin();
        half();
        fin();
        rst = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < 256; k++) ref_mem[k] = init_val(k);
        load = 1'b1;
        req_valid = '1;
        @(posedge clk);
        #1;
        load = 1'b0;

        // Reset with everything requesting
        do_reset();

        // Round-robin with all requesters held valid, distinct addresses
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 1'b0, 8'h30 + 8'(i), '0);
        half(); chk("rr_c0", req_ready, 4'b0011); fin();
        half(); chk("rr_c1", req_ready, 4'b1100); fin();
        half(); chk("rr_c2", req_ready, 4'b0011); fin();

        // Single read of a known word
        idle();
        set_req(2, 1'b1, 1'b0, 8'h10, '0);
        half();
        chk("single_ready", req_ready, 4'b0100);
        chk("single_addr_a", ram_addr_a, 8'h10);
        fin();
        idle();
        half();
        chk("single_rsp_valid", rsp_valid, 4'b0100);
        chk("single_rsp_data", rsp_rdata[2*DW +: DW], 16'hBEEF);
        fin();

        // Write/read hazard on the same address from ptr=0
        do_reset();
        idle();
        set_req(0, 1'b1, 1'b1, 8'h22, 16'h1234);
        set_req(1, 1'b1, 1'b0, 8'h22, '0);
        half(); chk("haz_ready", req_ready, 4'b0001); fin();
        req_valid[0] = 1'b0;
        half();
        chk("haz_retry_ready", req_ready, 4'b0010);
        chk("haz_retry_addr_a", ram_addr_a, 8'h22);
        fin();
        idle();
        half();
        chk("haz_rsp_data", rsp_rdata[1*DW +: DW], 16'h1234);
`ifdef DPRAM_ARB_COLL_CNT_EN
        chk("haz_coll_cnt", coll_cnt, 1);
`endif
        fin();

        // Read/read on the same address is allowed on both ports
        idle();
        set_req(1, 1'b1, 1'b0, 8'h05, '0);
        set_req(3, 1'b1, 1'b0, 8'h05, '0);
        half(); chk("rr_same_ready", req_ready, 4'b1010); fin();
        idle();
        half();
        chk("rr_same_valid", rsp_valid, 4'b1010);
        chk("rr_same_data1", rsp_rdata[1*DW +: DW], ref_mem[5]);
        chk("rr_same_data3", rsp_rdata[3*DW +: DW], ref_mem[5]);
        fin();

        // Reset right after a read grant drops the response
        idle();
        set_req(0, 1'b1, 1'b0, 8'h07, '0);
        half(); fin();
        rst = 1'b1;
        sb.delete();
        idle();
        half(); chk("midrst_rsp_valid", rsp_valid, 0); fin();
        rst = 1'b0;
        req_valid = '1;
        half(); chk("midrst_ptr0", req_ready, 4'b0011); fin();

        // Random traffic; narrow address range provokes hazards
        repeat (400) begin
            for (int i = 0; i < NREQ; i++)
                set_req(i, 1'($urandom), 1'($urandom_range(0, 2) == 0),
                        8'($urandom_range(0, 7)), 16'($urandom));
            half();
            fin();
        end
        idle();
        repeat (3) begin
            half();
            fin();
        end
        chk("scoreboard_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
